// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reset_seq_pkg
// Purpose : Shared constants for the staged reset sequencer.
//           Contains the FSM state encodings, the reset-cause codes and a
//           helper function that sizes the shared cycle counter.
// Rev     : 1.0  initial release
// ============================================================================
package reset_seq_pkg;

    // Sequencer FSM state encodings
    localparam logic [1:0] ST_HOLD = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;

    // Reset-cause codes reported on reset_cause (2'b11 is reserved)
    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    // Largest of three timing parameters; used to size the cycle counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : reset_sequencer_if
// Purpose : Request/status bundle between the reset sequencer and the
//           system. The master side raises requests and reports stage
//           readiness; the slave side (the sequencer) drives resets/status.
// Rev     : 1.0  initial release
// ============================================================================
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  sw_reset_req;
    logic                  wdt_kick;
    logic [NUM_STAGES-1:0] stage_ready;
    logic [NUM_STAGES-1:0] rst_out;
    logic                  busy;
    logic [1:0]            reset_cause;
    logic [NUM_STAGES-1:0] stage_fault;

    modport master (
        output sw_reset_req, wdt_kick, stage_ready,
        input  rst_out, busy, reset_cause, stage_fault
    );

    modport slave (
        input  sw_reset_req, wdt_kick, stage_ready,
        output rst_out, busy, reset_cause, stage_fault
    );
endinterface
`default_nettype wire

// File: rtl/reset_sequencer_wdt_timer.sv
`default_nettype none
// ============================================================================
// Module  : reset_wdt_timer
// Purpose : Watchdog period counter. Counts while enabled, clears on clr_i
//           or when disabled, and pulses expire_o for one cycle when the
//           count reaches PERIOD-1 without a clear.
// Rev     : 1.0  initial release
// ============================================================================
module reset_wdt_timer #(
    parameter int WIDTH  = 25,
    parameter int PERIOD = 25000000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en_i,
    input  wire logic clr_i,
    output logic      expire_o
);
    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(PERIOD - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear on kick, when idle, or on wrap at expiry
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || !en_i || (cnt_q == c_LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clr_i && (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : reset_sequencer
// Purpose : Releases staged reset outputs in order (stage 0 first) after a
//           hold period, waiting on each stage's ready flag with a timeout.
//           Handles software and watchdog re-reset requests and records
//           the cause of the last sequence.
// Options : RESET_SEQ_WATCHDOG_EN - include the watchdog timer
// Rev     : 1.0  initial release
// ============================================================================
import reset_seq_pkg::*;

module reset_sequencer #(
    parameter int NUM_STAGES    = 3,
    parameter int HOLD_CYCLES   = 32,
    parameter int STAGE_DELAY   = 16,
    parameter int READY_TIMEOUT = 255,
    parameter int WDT_CYCLES    = 25000000
) (
    input  wire logic         clk,
    input  wire logic         rst,
    reset_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(max3(HOLD_CYCLES, STAGE_DELAY, READY_TIMEOUT) + 1);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] c_HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DELAY_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] c_TO_LAST    = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX   = IDX_W'(NUM_STAGES - 1);

    logic [1:0]            state_q, state_d;
    // cnt_q times HOLD and the ready-qualified stage delay; to_q must run
    // alongside it in WAIT, so the ready timeout has its own register.
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      to_q, to_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
    logic                  busy_q, busy_d;
    logic [1:0]            cause_q, cause_d;
    logic [NUM_STAGES-1:0] fault_q, fault_d;

    logic                  w_wdt_expire;
    logic                  w_ready;
    logic [IDX_W-1:0]      w_idx_next;

`ifdef RESET_SEQ_WATCHDOG_EN
    reset_wdt_timer #(
        .WIDTH  (25),
        .PERIOD (WDT_CYCLES)
    ) u_wdt (
        .clk      (clk),
        .rst      (rst),
        .en_i     (state_q == ST_RUN),
        .clr_i    (bus.wdt_kick),
        .expire_o (w_wdt_expire)
    );
`else
    // Without the watchdog the kick input and period are intentionally dead
    logic w_unused_kick;
    assign w_unused_kick = bus.wdt_kick ^ (WDT_CYCLES == 0);
    assign w_wdt_expire  = 1'b0;
`endif

    assign w_ready    = bus.stage_ready[idx_q];
    assign w_idx_next = idx_q + 1'b1;

    // Sequencer next-state: requests first, then per-state progression
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        busy_d    = busy_q;
        cause_d   = cause_q;
        fault_d   = fault_q;
        if (bus.sw_reset_req || w_wdt_expire) begin
            // Software wins when both requests land together
            state_d   = ST_HOLD;
            cnt_d     = '0;
            to_d      = '0;
            idx_d     = '0;
            rst_out_d = '1;
            busy_d    = 1'b1;
            cause_d   = bus.sw_reset_req ? CAUSE_SW : CAUSE_WDT;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == c_HOLD_LAST) begin
                        rst_out_d[0] = 1'b0;
                        idx_d        = '0;
                        cnt_d        = '0;
                        to_d         = '0;
                        state_d      = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if ((w_ready && (cnt_q == c_DELAY_LAST)) ||
                        (!w_ready && (to_q == c_TO_LAST))) begin
                        if (!w_ready) begin
                            fault_d[idx_q] = 1'b1;
                        end
                        cnt_d = '0;
                        to_d  = '0;
                        if (idx_q < c_LAST_IDX) begin
                            rst_out_d[w_idx_next] = 1'b0;
                            idx_d                 = w_idx_next;
                        end else begin
                            state_d = ST_RUN;
                            busy_d  = 1'b0;
                        end
                    end else if (w_ready) begin
                        // Delay holds (does not clear) while ready is low
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    rst_out_d = '0;
                end
                default: begin
                    state_d   = ST_HOLD;
                    cnt_d     = '0;
                    to_d      = '0;
                    idx_d     = '0;
                    rst_out_d = '1;
                    busy_d    = 1'b1;
                end
            endcase
        end
    end

    // State registers; rst forces full assertion and clears the fault record
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            to_q      <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            busy_q    <= 1'b1;
            cause_q   <= CAUSE_POR;
            fault_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            busy_q    <= busy_d;
            cause_q   <= cause_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.rst_out     = rst_out_q;
    assign bus.busy        = busy_q;
    assign bus.reset_cause = cause_q;
    assign bus.stage_fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_reset_sequencer
// Purpose : Directed self-checking bench for reset_sequencer with
//           NUM_STAGES=3, HOLD=32, DELAY=16, TIMEOUT=255, WDT_CYCLES=100.
//           Watchdog scenarios are built when RESET_SEQ_WATCHDOG_EN is set.
// Rev     : 1.0  initial release
// ============================================================================
module tb_reset_sequencer;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    reset_sequencer_if #(.NUM_STAGES(3)) bus ();

    reset_sequencer #(
        .NUM_STAGES    (3),
        .HOLD_CYCLES   (32),
        .STAGE_DELAY   (16),
        .READY_TIMEOUT (255),
        .WDT_CYCLES    (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n active edges; return at the following falling edge
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Pulse rst for two edges; the next edge after return is cycle 1
    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    // Walk a full sequence from cycle 0 with all stages ready
    task automatic expect_full_sequence(input string tag, input logic [1:0] cause_exp);
        int         edges [8] = '{31, 32, 47, 48, 63, 64, 79, 80};
        logic [2:0] ro    [8] = '{3'b111, 3'b110, 3'b110, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
        logic       bz    [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int         now;
        now = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(edges[k] - now);
            now = edges[k];
            tests++;
            if (bus.rst_out !== ro[k] || bus.busy !== bz[k]) begin
                fails++;
                $display("FAIL %s cycle %0d: rst_out=%b busy=%b, expected rst_out=%b busy=%b",
                         tag, now, bus.rst_out, bus.busy, ro[k], bz[k]);
            end
        end
        tests++;
        if (bus.reset_cause !== cause_exp) begin
            fails++;
            $display("FAIL %s cause: got %b expected %b", tag, bus.reset_cause, cause_exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        tests++;
        if (bus.rst_out !== 3'b111 || bus.busy !== 1'b1 ||
            bus.reset_cause !== 2'b00 || bus.stage_fault !== 3'b000) begin
            fails++;
            $display("FAIL reset_state: rst_out=%b busy=%b cause=%b fault=%b, expected 111 1 00 000",
                     bus.rst_out, bus.busy, bus.reset_cause, bus.stage_fault);
        end
        rst = 1'b0;
        expect_full_sequence("por_sequence", 2'b00);
    endtask

    task automatic test_sw_reset();
        cyc(5);
        bus.sw_reset_req = 1'b1;
        cyc(1);
        bus.sw_reset_req = 1'b0;
        tests++;
        if (bus.rst_out !== 3'b111 || bus.busy !== 1'b1 || bus.reset_cause !== 2'b01) begin
            fails++;
            $display("FAIL sw_load: rst_out=%b busy=%b cause=%b, expected 111 1 01",
                     bus.rst_out, bus.busy, bus.reset_cause);
        end
        expect_full_sequence("sw_sequence", 2'b01);
    endtask

    task automatic test_stage_timeout();
        bus.stage_ready = 3'b101;
        do_reset();
        cyc(48);
        tests++;
        if (bus.rst_out !== 3'b100 || bus.stage_fault !== 3'b000) begin
            fails++;
            $display("FAIL to_stage1_entry: rst_out=%b fault=%b, expected 100 000",
                     bus.rst_out, bus.stage_fault);
        end
        cyc(254);
        tests++;
        if (bus.rst_out !== 3'b100 || bus.stage_fault !== 3'b000) begin
            fails++;
            $display("FAIL to_before_expiry: rst_out=%b fault=%b, expected 100 000",
                     bus.rst_out, bus.stage_fault);
        end
        cyc(1);
        tests++;
        if (bus.rst_out !== 3'b000 || bus.stage_fault !== 3'b010 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL to_expiry: rst_out=%b fault=%b busy=%b, expected 000 010 1",
                     bus.rst_out, bus.stage_fault, bus.busy);
        end
        cyc(15);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL to_busy_hold: busy=%b expected 1", bus.busy);
        end
        cyc(1);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL to_busy_fall: busy=%b expected 0", bus.busy);
        end
        bus.stage_ready = 3'b111;
        bus.sw_reset_req = 1'b1;
        cyc(1);
        bus.sw_reset_req = 1'b0;
        tests++;
        if (bus.stage_fault !== 3'b010 || bus.rst_out !== 3'b111) begin
            fails++;
            $display("FAIL fault_after_sw: fault=%b rst_out=%b, expected 010 111",
                     bus.stage_fault, bus.rst_out);
        end
        expect_full_sequence("sw_after_fault", 2'b01);
        tests++;
        if (bus.stage_fault !== 3'b010) begin
            fails++;
            $display("FAIL fault_sticky: fault=%b expected 010", bus.stage_fault);
        end
    endtask

    task automatic test_mid_restart();
        do_reset();
        tests++;
        if (bus.stage_fault !== 3'b000) begin
            fails++;
            $display("FAIL fault_cleared_by_rst: fault=%b expected 000", bus.stage_fault);
        end
        cyc(39);
        tests++;
        if (bus.rst_out !== 3'b110) begin
            fails++;
            $display("FAIL mid_before: rst_out=%b expected 110", bus.rst_out);
        end
        bus.sw_reset_req = 1'b1;
        cyc(1);
        bus.sw_reset_req = 1'b0;
        tests++;
        if (bus.rst_out !== 3'b111 || bus.busy !== 1'b1 || bus.reset_cause !== 2'b01) begin
            fails++;
            $display("FAIL mid_load: rst_out=%b busy=%b cause=%b, expected 111 1 01",
                     bus.rst_out, bus.busy, bus.reset_cause);
        end
        expect_full_sequence("mid_restart", 2'b01);
    endtask

    task automatic test_ready_toggle();
        do_reset();
        cyc(32);
        for (int e = 33; e <= 63; e++) begin
            bus.stage_ready[0] = (e % 2 == 1);
            cyc(1);
            if (e == 62) begin
                tests++;
                if (bus.rst_out !== 3'b110) begin
                    fails++;
                    $display("FAIL toggle_hold: rst_out=%b expected 110 at cycle 62", bus.rst_out);
                end
            end
        end
        bus.stage_ready = 3'b111;
        tests++;
        if (bus.rst_out !== 3'b100) begin
            fails++;
            $display("FAIL toggle_release: rst_out=%b expected 100 at cycle 63", bus.rst_out);
        end
    endtask

`ifdef RESET_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        do_reset();
        cyc(80);
        cyc(99);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL wdt_before_expiry: busy=%b expected 0", bus.busy);
        end
        cyc(1);
        tests++;
        if (bus.busy !== 1'b1 || bus.rst_out !== 3'b111 || bus.reset_cause !== 2'b10) begin
            fails++;
            $display("FAIL wdt_expiry: busy=%b rst_out=%b cause=%b, expected 1 111 10",
                     bus.busy, bus.rst_out, bus.reset_cause);
        end
        do_reset();
        cyc(80);
        for (int k = 0; k < 6; k++) begin
            cyc(49);
            bus.wdt_kick = 1'b1;
            cyc(1);
            bus.wdt_kick = 1'b0;
        end
        tests++;
        if (bus.busy !== 1'b0 || bus.reset_cause !== 2'b00) begin
            fails++;
            $display("FAIL wdt_kicked: busy=%b cause=%b, expected 0 00", bus.busy, bus.reset_cause);
        end
        do_reset();
        cyc(179);
        bus.sw_reset_req = 1'b1;
        cyc(1);
        bus.sw_reset_req = 1'b0;
        tests++;
        if (bus.reset_cause !== 2'b01 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL sw_wdt_same_cycle: cause=%b busy=%b, expected 01 1",
                     bus.reset_cause, bus.busy);
        end
    endtask
`else
    task automatic test_no_watchdog();
        do_reset();
        cyc(80);
        bus.wdt_kick = 1'b1;
        cyc(1);
        bus.wdt_kick = 1'b0;
        cyc(200);
        tests++;
        if (bus.busy !== 1'b0 || bus.rst_out !== 3'b000 || bus.reset_cause !== 2'b00) begin
            fails++;
            $display("FAIL no_wdt: busy=%b rst_out=%b cause=%b, expected 0 000 00",
                     bus.busy, bus.rst_out, bus.reset_cause);
        end
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tests            = 0;
        fails            = 0;
        rst              = 1'b1;
        bus.sw_reset_req = 1'b0;
        bus.wdt_kick     = 1'b0;
        bus.stage_ready  = 3'b111;
        @(negedge clk);
        test_reset();
        test_sw_reset();
        test_stage_timeout();
        test_mid_restart();
        test_ready_toggle();
`ifdef RESET_SEQ_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
